lifo_arbiter: RTL and testbench

Arbiter and sequencer that shares one `lifo` instance between NREQ requesters, each issuing push or pop requests over a req/ack handshake. It picks one eligible requester per cycle and drives the LIFO's `wrreq_i`/`rdreq_i`/`data_i` from registers. It returns pop data to the winner with a per-requester valid strobe. Occupancy is tracked with an internal shadow counter, so grants never depend on the LIFO's lagging status flags.

---
 rtl/lifo_arb_pkg.sv | 15 +
 rtl/lifo_arbiter_rr_picker.sv | 33 +++
 rtl/lifo_arbiter.sv | 128 ++++++++++++
 tb/tb_lifo_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lifo_arb_pkg.sv
// lifo_arb_pkg: shared types and helpers for the LIFO arbiter slice.
package lifo_arb_pkg;

   // Per-requester operation encoding carried on op_i
   typedef enum logic {
      OP_PUSH = 1'b0,
      OP_POP  = 1'b1
   } op_t;

   // Number of words the LIFO holds for a given address width
   function automatic int unsigned capacity(input int unsigned awidth);
      return 32'd1 << awidth;
   endfunction

endpackage : lifo_arb_pkg

// File: rtl/lifo_arbiter_rr_picker.sv
// rr_picker: picks one requester from an eligible mask, searching upward
// from ptr and wrapping. Returns the winner one-hot and as a binary index.
// With ptr tied to zero it degenerates to fixed priority, index 0 highest.
module rr_picker
   import lifo_arb_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] eligible,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   idx,
   output logic            found
);

   // First eligible requester at or after ptr, modulo NREQ
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         logic [IW-1:0] cand;
         cand = IW'((32'(ptr) + i) % NREQ);
         if (!found && eligible[cand]) begin
            found = 1'b1;
            idx   = cand;
            grant = NREQ'(1) << cand;
         end
      end
   end

endmodule : rr_picker

// File: rtl/lifo_arbiter.sv
// lifo_arbiter: shares one LIFO between NREQ push/pop requesters.
// Build option: define LIFO_ARB_RR_EN for round-robin arbitration; otherwise
// fixed priority with requester 0 highest.
// Occupancy is tracked by a shadow counter so grants never wait on the
// LIFO's own status flags, which lag the strobes by one cycle.
module lifo_arbiter
   import lifo_arb_pkg::*;
#(
   parameter int unsigned DWIDTH = 16,
   parameter int unsigned AWIDTH = 8,
   parameter int unsigned NREQ   = 4
) (
   input  logic                   clk_i,
   input  logic                   srst_i,
   input  logic [NREQ-1:0]        req_i,
   input  logic [NREQ-1:0]        op_i,
   input  logic [NREQ*DWIDTH-1:0] wdata_i,
   output logic [NREQ-1:0]        ack_o,
   output logic [NREQ-1:0]        rvalid_o,
   output logic [DWIDTH-1:0]      rdata_o,
   output logic [AWIDTH:0]        usedw_o,
   output logic [DWIDTH-1:0]      lifo_data_o,
   output logic                   lifo_wrreq_o,
   output logic                   lifo_rdreq_o,
   input  logic [DWIDTH-1:0]      lifo_q_i
);

   localparam int unsigned IW = $clog2(NREQ);
   localparam int unsigned UW = AWIDTH + 1;
   localparam logic [AWIDTH:0] CAP = UW'(capacity(AWIDTH));

   logic [DWIDTH-1:0] wdata_arr [NREQ];
   logic [NREQ-1:0]   eligible;
   logic [NREQ-1:0]   win_onehot;
   logic [IW-1:0]     win_idx;
   logic              win_found;
   op_t               win_op;
   logic              full;
   logic              empty;
   logic [IW-1:0]     ptr;
   logic              pend;
   logic [IW-1:0]     pend_idx;
   logic [NREQ-1:0]   rvalid_q;

   // Unpack the flattened push data bus into one word per requester
   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign wdata_arr[g] = wdata_i[g*DWIDTH +: DWIDTH];
   end

   assign full  = (usedw_o == CAP);
   assign empty = (usedw_o == '0);

   // Eligible: requesting, operation possible at current occupancy, and not
   // in its own ack cycle (its req_i may still be the request just served)
   always_comb begin
      eligible = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         eligible[k] = req_i[k] && !ack_o[k]
                       && !((op_t'(op_i[k]) == OP_PUSH) && full)
                       && !((op_t'(op_i[k]) == OP_POP)  && empty);
      end
   end

   rr_picker #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_picker (
      .eligible (eligible),
      .ptr      (ptr),
      .grant    (win_onehot),
      .idx      (win_idx),
      .found    (win_found)
   );

   assign win_op = op_t'(op_i[win_idx]);

`ifdef LIFO_ARB_RR_EN
   // Round-robin pointer: search resumes just past the last winner
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         ptr <= '0;
      end else if (win_found) begin
         ptr <= (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);
      end
   end
`else
   assign ptr = '0;
`endif

   // Grant edge: ack pulse, LIFO strobe, push data and shadow occupancy
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         ack_o        <= '0;
         lifo_wrreq_o <= 1'b0;
         lifo_rdreq_o <= 1'b0;
         lifo_data_o  <= '0;
         usedw_o      <= '0;
      end else begin
         ack_o        <= win_found ? win_onehot : '0;
         lifo_wrreq_o <= win_found && (win_op == OP_PUSH);
         lifo_rdreq_o <= win_found && (win_op == OP_POP);
         if (win_found && (win_op == OP_PUSH)) begin
            lifo_data_o <= wdata_arr[win_idx];
            usedw_o     <= usedw_o + UW'(1);
         end else if (win_found) begin
            usedw_o     <= usedw_o - UW'(1);
         end
      end
   end

   // Pop return tracking: remember the pop winner, strobe it when q is valid
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         pend     <= 1'b0;
         pend_idx <= '0;
         rvalid_q <= '0;
      end else begin
         pend     <= win_found && (win_op == OP_POP);
         pend_idx <= win_idx;
         rvalid_q <= pend ? (NREQ'(1) << pend_idx) : '0;
      end
   end

   // A reset arriving while the strobe is due cancels it
   assign rvalid_o = srst_i ? '0 : rvalid_q;
   assign rdata_o  = (rvalid_o != '0) ? lifo_q_i : '0;

endmodule : lifo_arbiter

// File: tb/tb_lifo_arbiter.sv
// tb_lifo_arbiter: directed bench for lifo_arbiter driving a behavioural
// LIFO (AWIDTH=3, 8 words). Covers both builds via LIFO_ARB_RR_EN.
module tb_lifo_arbiter;

   localparam int unsigned DW = 16;
   localparam int unsigned AW = 3;
   localparam int unsigned NR = 4;

   logic             clk = 1'b0;
   logic             srst;
   logic [NR-1:0]    req;
   logic [NR-1:0]    op;
   logic [NR*DW-1:0] wdata;
   logic [NR-1:0]    ack;
   logic [NR-1:0]    rvalid;
   logic [DW-1:0]    rdata;
   logic [AW:0]      usedw;
   logic [DW-1:0]    ldata;
   logic             wr;
   logic             rd;
   logic [DW-1:0]    lq;

   int unsigned vectors = 0;
   int unsigned errors  = 0;

   always #5 clk = ~clk;

   lifo_arbiter #(
      .DWIDTH (DW),
      .AWIDTH (AW),
      .NREQ   (NR)
   ) dut (
      .clk_i        (clk),
      .srst_i       (srst),
      .req_i        (req),
      .op_i         (op),
      .wdata_i      (wdata),
      .ack_o        (ack),
      .rvalid_o     (rvalid),
      .rdata_o      (rdata),
      .usedw_o      (usedw),
      .lifo_data_o  (ldata),
      .lifo_wrreq_o (wr),
      .lifo_rdreq_o (rd),
      .lifo_q_i     (lq)
   );

   // Behavioural LIFO: registered q, usedw updated at the strobe edge
   logic [DW-1:0] mem [8];
   logic [AW:0]   lused;
   always_ff @(posedge clk) begin
      if (srst) begin
         lused <= '0;
         lq    <= '0;
      end else if (wr && lused < 4'd8) begin
         mem[lused[2:0]] <= ldata;
         lused           <= lused + 4'd1;
      end else if (rd && lused != 4'd0) begin
         lq    <= mem[3'(lused - 4'd1)];
         lused <= lused - 4'd1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      srst = 1'b1;
      req  = '0;
      op   = '0;
      tick();
      tick();
      srst = 1'b0;
   endtask

   task automatic test_reset();
      srst  = 1'b1;
      req   = 4'hF;
      op    = '0;
      wdata = '0;
      for (int c = 0; c < 2; c++) begin
         tick();
         vectors++;
         if ({ack, rvalid, rdata, usedw, ldata, wr, rd} !== 46'd0) begin
            errors++;
            $display("FAIL reset_outputs cyc%0d: ack=%b rvalid=%b rdata=%h usedw=%0d ldata=%h wr=%b rd=%b, want all 0",
                     c, ack, rvalid, rdata, usedw, ldata, wr, rd);
         end
      end
      srst = 1'b0;
      tick();
      vectors++;
      if ({ack, wr, rd, usedw} !== {4'b0001, 1'b1, 1'b0, 4'd1}) begin
         errors++;
         $display("FAIL reset_first_ack: ack=%b wr=%b rd=%b usedw=%0d, want 0001 1 0 1", ack, wr, rd, usedw);
      end
      req = '0;
      do_reset();
   endtask

   task automatic test_push_pop();
      do_reset();
      req   = 4'b0001;
      op    = 4'b0000;
      wdata = 64'h0000_0000_0000_A5A5;
      tick();
      vectors++;
      if ({ack, wr, rd, usedw, ldata} !== {4'b0001, 1'b1, 1'b0, 4'd1, 16'hA5A5}) begin
         errors++;
         $display("FAIL push_ack: ack=%b wr=%b rd=%b usedw=%0d ldata=%h, want 0001 1 0 1 a5a5", ack, wr, rd, usedw, ldata);
      end
      op = 4'b0001;
      tick();
      vectors++;
      if ({ack, wr, rd, usedw} !== {4'b0000, 1'b0, 1'b0, 4'd1}) begin
         errors++;
         $display("FAIL ack_mask: ack=%b wr=%b rd=%b usedw=%0d, want 0000 0 0 1", ack, wr, rd, usedw);
      end
      tick();
      vectors++;
      if ({ack, wr, rd, usedw, ldata} !== {4'b0001, 1'b0, 1'b1, 4'd0, 16'hA5A5}) begin
         errors++;
         $display("FAIL pop_ack: ack=%b wr=%b rd=%b usedw=%0d ldata=%h, want 0001 0 1 0 a5a5", ack, wr, rd, usedw, ldata);
      end
      req = '0;
      tick();
      vectors++;
      if ({rvalid, rdata, ack, lused} !== {4'b0001, 16'hA5A5, 4'b0000, 4'd0}) begin
         errors++;
         $display("FAIL pop_data: rvalid=%b rdata=%h ack=%b lifo_used=%0d, want 0001 a5a5 0000 0", rvalid, rdata, ack, lused);
      end
      tick();
      vectors++;
      if ({rvalid, rdata} !== 20'd0) begin
         errors++;
         $display("FAIL pop_strobe_end: rvalid=%b rdata=%h, want 0 0", rvalid, rdata);
      end
   endtask

`ifdef LIFO_ARB_RR_EN
   task automatic test_fairness();
      do_reset();
      req   = 4'hF;
      op    = 4'b0000;
      wdata = 64'h4444_3333_2222_1111;
      for (int i = 0; i < 8; i++) begin
         logic [NR-1:0] exp_ack;
         logic [DW-1:0] exp_data;
         exp_ack  = 4'b0001 << (i % 4);
         exp_data = 16'h1111 * 16'((i % 4) + 1);
         tick();
         vectors++;
         if ({ack, usedw, ldata} !== {exp_ack, 4'(i + 1), exp_data}) begin
            errors++;
            $display("FAIL rr_order grant%0d: ack=%b usedw=%0d ldata=%h, want %b %0d %h",
                     i, ack, usedw, ldata, exp_ack, i + 1, exp_data);
         end
      end
      tick();
      vectors++;
      if ({ack, wr, usedw} !== {4'b0000, 1'b0, 4'd8}) begin
         errors++;
         $display("FAIL rr_full_stall: ack=%b wr=%b usedw=%0d, want 0000 0 8", ack, wr, usedw);
      end
      req = '0;
      tick();
   endtask
`else
   task automatic test_fixed_priority();
      do_reset();
      req   = 4'b0101;
      op    = 4'b0000;
      wdata = 64'h0000_2222_0000_1111;
      for (int i = 0; i < 6; i++) begin
         logic [NR-1:0] exp_ack;
         logic [DW-1:0] exp_data;
         exp_ack  = (i % 2 == 0) ? 4'b0001 : 4'b0100;
         exp_data = (i % 2 == 0) ? 16'h1111 : 16'h2222;
         tick();
         vectors++;
         if ({ack, usedw, ldata} !== {exp_ack, 4'(i + 1), exp_data}) begin
            errors++;
            $display("FAIL fixed_prio grant%0d: ack=%b usedw=%0d ldata=%h, want %b %0d %h",
                     i, ack, usedw, ldata, exp_ack, i + 1, exp_data);
         end
      end
      req = '0;
      tick();
   endtask
`endif

   task automatic test_full();
      do_reset();
      req   = 4'b1001;
      op    = 4'b0000;
      wdata = 64'h3A00_0000_1B1B_0A00;
      for (int i = 0; i < 8; i++) begin
         logic [NR-1:0] exp_ack;
         exp_ack = (i % 2 == 0) ? 4'b0001 : 4'b1000;
         tick();
         vectors++;
         if ({ack, usedw} !== {exp_ack, 4'(i + 1)}) begin
            errors++;
            $display("FAIL fill grant%0d: ack=%b usedw=%0d, want %b %0d", i, ack, usedw, exp_ack, i + 1);
         end
      end
      req = 4'b0110;
      op  = 4'b0100;
      tick();
      vectors++;
      if ({ack, wr, rd, usedw} !== {4'b0100, 1'b0, 1'b1, 4'd7}) begin
         errors++;
         $display("FAIL full_pop_first: ack=%b wr=%b rd=%b usedw=%0d, want 0100 0 1 7", ack, wr, rd, usedw);
      end
      req = 4'b0010;
      tick();
      vectors++;
      if ({ack, wr, rd, usedw, ldata, rvalid, rdata} !==
          {4'b0010, 1'b1, 1'b0, 4'd8, 16'h1B1B, 4'b0100, 16'h3A00}) begin
         errors++;
         $display("FAIL full_push_next: ack=%b wr=%b rd=%b usedw=%0d ldata=%h rvalid=%b rdata=%h, want 0010 1 0 8 1b1b 0100 3a00",
                  ack, wr, rd, usedw, ldata, rvalid, rdata);
      end
      req = '0;
      tick();
      vectors++;
      if ({ack, rvalid, usedw, lused} !== {4'b0000, 4'b0000, 4'd8, 4'd8}) begin
         errors++;
         $display("FAIL full_settle: ack=%b rvalid=%b usedw=%0d lifo_used=%0d, want 0000 0000 8 8", ack, rvalid, usedw, lused);
      end
   endtask

   task automatic test_empty_and_reset();
      do_reset();
      req   = 4'b1000;
      op    = 4'b1000;
      wdata = 64'h0000_0000_0000_1234;
      for (int c = 0; c < 2; c++) begin
         tick();
         vectors++;
         if ({ack, rd, usedw} !== 9'd0) begin
            errors++;
            $display("FAIL empty_stall cyc%0d: ack=%b rd=%b usedw=%0d, want 0000 0 0", c, ack, rd, usedw);
         end
      end
      req = 4'b1001;
      tick();
      vectors++;
      if ({ack, wr, usedw} !== {4'b0001, 1'b1, 4'd1}) begin
         errors++;
         $display("FAIL empty_unblock_push: ack=%b wr=%b usedw=%0d, want 0001 1 1", ack, wr, usedw);
      end
      req = 4'b1000;
      tick();
      vectors++;
      if ({ack, rd, usedw} !== {4'b1000, 1'b1, 4'd0}) begin
         errors++;
         $display("FAIL empty_pop_ack: ack=%b rd=%b usedw=%0d, want 1000 1 0", ack, rd, usedw);
      end
      req = '0;
      tick();
      vectors++;
      if ({rvalid, rdata} !== {4'b1000, 16'h1234}) begin
         errors++;
         $display("FAIL empty_pop_data: rvalid=%b rdata=%h, want 1000 1234", rvalid, rdata);
      end
      // reset arriving while a pop return is due
      req   = 4'b0001;
      op    = 4'b0000;
      wdata = 64'h0000_0000_0000_5678;
      tick();
      vectors++;
      if ({ack, usedw} !== {4'b0001, 4'd1}) begin
         errors++;
         $display("FAIL midrst_push: ack=%b usedw=%0d, want 0001 1", ack, usedw);
      end
      op = 4'b0001;
      tick();
      tick();
      vectors++;
      if ({ack, rd, usedw} !== {4'b0001, 1'b1, 4'd0}) begin
         errors++;
         $display("FAIL midrst_pop_ack: ack=%b rd=%b usedw=%0d, want 0001 1 0", ack, rd, usedw);
      end
      req = '0;
      tick();
      srst = 1'b1;
      #1;
      vectors++;
      if ({rvalid, rdata} !== 20'd0) begin
         errors++;
         $display("FAIL midrst_cancel: rvalid=%b rdata=%h, want 0 0", rvalid, rdata);
      end
      tick();
      vectors++;
      if ({ack, rvalid, rdata, usedw, lused} !== 32'd0) begin
         errors++;
         $display("FAIL midrst_clear: ack=%b rvalid=%b rdata=%h usedw=%0d lifo_used=%0d, want all 0",
                  ack, rvalid, rdata, usedw, lused);
      end
      srst = 1'b0;
      req  = 4'b0011;
      op   = 4'b0000;
      tick();
      vectors++;
      if (ack !== 4'b0001) begin
         errors++;
         $display("FAIL midrst_rearb: ack=%b, want 0001", ack);
      end
      req = '0;
      tick();
   endtask

   initial begin
      srst  = 1'b1;
      req   = '0;
      op    = '0;
      wdata = '0;
      test_reset();
      test_push_pop();
`ifdef LIFO_ARB_RR_EN
      test_fairness();
`else
      test_fixed_priority();
`endif
      test_full();
      test_empty_and_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule : tb_lifo_arbiter
